// File: rtl/addsub_pkg.sv
// Shared constants, types and helpers for the pipelined adder/subtractor.
package addsub_pkg;

   localparam logic OP_SUB = 1'b0;
   localparam logic OP_ADD = 1'b1;

   localparam int MIN_STAGES = 1;
   localparam int MAX_STAGES = 4;
   localparam int MAX_WIDTH  = 256;

   // Per-op control that rides alongside the data to the final stage.
   typedef struct packed {
      logic vld;
      logic add;
      logic sat;
      logic a_msb;
      logic bx_msb;
   } ctl_t;

   function automatic logic cfg_ok(input int width, input int stages);
      return (width >= 2) && (width <= MAX_WIDTH) &&
             (stages >= MIN_STAGES) && (stages <= MAX_STAGES) &&
             ((width % stages) == 0);
   endfunction

   function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
      logic [MAX_WIDTH-1:0] r;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         r[i] = (i < width - 1);
      end
      return r;
   endfunction

   function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
      logic [MAX_WIDTH-1:0] r;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         r[i] = (i == width - 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/addsub_slice.sv
// One carry-chain slice: a CHUNK-bit add with carry-in, result and carry registered.
module addsub_slice
   import addsub_pkg::*;
#(
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             sclr,
   input  logic             ce,
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK-1:0] sum_d, sum_q;
   logic             cout_d, cout_q;

   always_comb begin
      {cout_d, sum_d} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   end

   always_ff @(posedge clk or posedge sclr) begin
      if (sclr) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (ce) begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: carry chain cut into STAGES registered slices, with a
// matching valid pipe, clock-enable stall, optional signed saturation and status flags.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             CLK,
   input  logic             SCLR,
   input  logic             CE,
   input  logic             IN_VALID,
   input  logic             ADD,
   input  logic             SAT,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             OUT_VALID,
   output logic [WIDTH-1:0] S,
   output logic             C_OUT,
   output logic             OVF,
   output logic             ZERO
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int MSB   = WIDTH - 1;
   localparam logic [MAX_WIDTH-1:0] SAT_MAX_W = sat_max(WIDTH);
   localparam logic [MAX_WIDTH-1:0] SAT_MIN_W = sat_min(WIDTH);
   localparam logic [WIDTH-1:0]     SAT_MAX   = SAT_MAX_W[WIDTH-1:0];
   localparam logic [WIDTH-1:0]     SAT_MIN   = SAT_MIN_W[WIDTH-1:0];

   if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("addsub_pipe: illegal WIDTH/STAGES combination");
   end

   logic [WIDTH-1:0] bx_s;
   logic [WIDTH-1:0] raw_s;
   logic [CHUNK-1:0] slice_sum_s  [STAGES];
   logic             slice_cout_s [STAGES];
   ctl_t             ctl_d [STAGES];
   ctl_t             ctl_q [STAGES];
   ctl_t             fin_s;
   logic             carry_s;
   logic             ovf_s;
   logic [WIDTH-1:0] s_s;

   assign bx_s = (ADD == OP_ADD) ? B : ~B;

   always_comb begin
      ctl_d[0] = '{vld: IN_VALID, add: ADD, sat: SAT, a_msb: A[MSB], bx_msb: bx_s[MSB]};
      for (int j = 1; j < STAGES; j++) begin
         ctl_d[j] = ctl_q[j-1];
      end
   end

   always_ff @(posedge CLK or posedge SCLR) begin
      if (SCLR) begin
         for (int j = 0; j < STAGES; j++) ctl_q[j] <= '0;
      end else if (CE) begin
         for (int j = 0; j < STAGES; j++) ctl_q[j] <= ctl_d[j];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      logic [CHUNK-1:0] a_s, b_s;
      logic             cin_s;

      if (k == 0) begin : g_first
         assign a_s   = A[CHUNK-1:0];
         assign b_s   = bx_s[CHUNK-1:0];
         assign cin_s = ~ADD;
      end else begin : g_upper
         // Upper operand chunks wait k cycles so they meet the carry from slice k-1.
         logic [2*CHUNK-1:0] op_d [k];
         logic [2*CHUNK-1:0] op_q [k];

         always_comb begin
            op_d[0] = {A[k*CHUNK +: CHUNK], bx_s[k*CHUNK +: CHUNK]};
            for (int i = 1; i < k; i++) begin
               op_d[i] = op_q[i-1];
            end
         end

         always_ff @(posedge CLK or posedge SCLR) begin
            if (SCLR) begin
               for (int i = 0; i < k; i++) op_q[i] <= '0;
            end else if (CE) begin
               for (int i = 0; i < k; i++) op_q[i] <= op_d[i];
            end
         end

         assign a_s   = op_q[k-1][2*CHUNK-1:CHUNK];
         assign b_s   = op_q[k-1][CHUNK-1:0];
         assign cin_s = slice_cout_s[k-1];
      end

      addsub_slice #(.CHUNK(CHUNK)) u_slice (
         .clk  (CLK),
         .sclr (SCLR),
         .ce   (CE),
         .a    (a_s),
         .b    (b_s),
         .cin  (cin_s),
         .sum  (slice_sum_s[k]),
         .cout (slice_cout_s[k])
      );

      if (k == STAGES - 1) begin : g_last
         assign raw_s[k*CHUNK +: CHUNK] = slice_sum_s[k];
      end else begin : g_res
         // Finished lower chunks wait here until the top slice completes.
         localparam int DEPTH = STAGES - 1 - k;
         logic [CHUNK-1:0] res_d [DEPTH];
         logic [CHUNK-1:0] res_q [DEPTH];

         always_comb begin
            res_d[0] = slice_sum_s[k];
            for (int i = 1; i < DEPTH; i++) begin
               res_d[i] = res_q[i-1];
            end
         end

         always_ff @(posedge CLK or posedge SCLR) begin
            if (SCLR) begin
               for (int i = 0; i < DEPTH; i++) res_q[i] <= '0;
            end else if (CE) begin
               for (int i = 0; i < DEPTH; i++) res_q[i] <= res_d[i];
            end
         end

         assign raw_s[k*CHUNK +: CHUNK] = res_q[DEPTH-1];
      end
   end

   // Flags and clamp come straight off final-stage registers; qualified by valid so reset reads 0.
   always_comb begin
      fin_s   = ctl_q[STAGES-1];
      carry_s = slice_cout_s[STAGES-1];
      ovf_s   = (fin_s.a_msb == fin_s.bx_msb) && (raw_s[MSB] != fin_s.a_msb);
      if (fin_s.sat && ovf_s) begin
         s_s = fin_s.a_msb ? SAT_MIN : SAT_MAX;
      end else begin
         s_s = raw_s;
      end
      OUT_VALID = fin_s.vld;
      S         = s_s;
      C_OUT     = fin_s.vld & ((fin_s.add == OP_ADD) ? carry_s : ~carry_s);
      OVF       = fin_s.vld & ovf_s;
      ZERO      = fin_s.vld & (s_s == '0);
   end

endmodule
